// File: rtl/spi_xfer_sequencer_if.sv
// spi_xfer_sequencer_if: groups the TX/RX word streams and the bus-mapped SPI master
// port (addr/wr/rd/cs/data) used by spi_xfer_sequencer.
//   master modport: the sequencer itself (drives the SPI master port, serves the streams)
//   slave modport : the surroundings (word producer/consumer and the SPI master)
interface spi_xfer_sequencer_if;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [1:0]  spi_addr;
  logic [31:0] spi_wdata;
  logic [31:0] spi_rdata;
  logic        spi_rd;
  logic        spi_wr;
  logic        spi_cs;

  modport master (
    input  tx_data, tx_valid, rx_ready, spi_rdata,
    output tx_ready, rx_data, rx_valid, spi_addr, spi_wdata, spi_rd, spi_wr, spi_cs
  );

  modport slave (
    output tx_data, tx_valid, rx_ready, spi_rdata,
    input  tx_ready, rx_data, rx_valid, spi_addr, spi_wdata, spi_rd, spi_wr, spi_cs
  );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: streaming front-end for the bus-mapped SPI master. Buffers 32-bit
// words in a TX FIFO, programs clkdiv, writes each word to the master, polls busy and
// (optionally) reads the received word back into an RX FIFO.
// Build option: define SPI_RX_CAPTURE_EN to keep the RX FIFO and the READ step; without
// it the block is outbound-only and rx_valid/rx_data are tied to zero.
module spi_xfer_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter logic [7:0]  CLKDIV_RST = 8'd4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  cfg_clkdiv,
  input  logic                        cfg_load,
  output logic                        idle,
  output logic [15:0]                 xfer_count,
  spi_xfer_sequencer_if.master        bus
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Register map of the SPI master
  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DIV  = 2'b10;

`ifdef SPI_RX_CAPTURE_EN
  typedef enum logic [2:0] {
    ST_SYNC, ST_CFG, ST_IDLE, ST_WRITE, ST_SETTLE, ST_POLL, ST_READ
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_SYNC, ST_CFG, ST_IDLE, ST_WRITE, ST_SETTLE, ST_POLL
  } state_t;
`endif

  state_t      state_q, state_d;
  logic        cs_d, rd_d, wr_d;
  logic [1:0]  addr_d;
  logic [31:0] wdata_d;
  logic [7:0]  clkdiv_q, clkdiv_d;
  logic        cfg_pending_q;
  logic        word_done;

  // ---------------------------------------------------------------------------
  // TX FIFO: extra pointer bit distinguishes full from empty
  // ---------------------------------------------------------------------------
  logic [31:0] tx_mem [DEPTH];
  logic [AW:0] tx_wr_ptr, tx_rd_ptr;
  logic        tx_empty, tx_full, tx_push, tx_pop;

  assign tx_empty     = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full      = (tx_wr_ptr[AW] != tx_rd_ptr[AW]) &&
                        (tx_wr_ptr[AW-1:0] == tx_rd_ptr[AW-1:0]);
  assign bus.tx_ready = !rst && !tx_full;
  assign tx_push      = bus.tx_valid && bus.tx_ready;
  assign tx_pop       = (state_q == ST_WRITE) && !tx_empty;

  // TX storage write
  // NOTE: FIFO storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[AW-1:0]] <= bus.tx_data;
  end

  // TX pointer update
  // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO (only with capture enabled)
  // ---------------------------------------------------------------------------
`ifdef SPI_RX_CAPTURE_EN
  logic [31:0] rx_mem [DEPTH];
  logic [AW:0] rx_wr_ptr, rx_rd_ptr;
  logic        rx_empty, rx_full, rx_push, rx_pop;

  assign rx_empty     = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full      = (rx_wr_ptr[AW] != rx_rd_ptr[AW]) &&
                        (rx_wr_ptr[AW-1:0] == rx_rd_ptr[AW-1:0]);
  // A full FIFO at cycle start refuses the push even if a pop happens in the same cycle
  assign rx_push      = (state_q == ST_READ) && !rx_full;
  assign rx_pop       = bus.rx_ready && !rx_empty;
  assign bus.rx_valid = !rx_empty;
  assign bus.rx_data  = rx_mem[rx_rd_ptr[AW-1:0]];
  assign word_done    = rx_push;

  // RX storage write
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr[AW-1:0]] <= bus.spi_rdata;
  end

  // RX pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
    end
  end
`else
  logic unused_rx;

  assign bus.rx_valid = 1'b0;
  assign bus.rx_data  = '0;
  assign word_done    = (state_q == ST_POLL) && !bus.spi_rdata[0];
  assign unused_rx    = &{1'b0, bus.rx_ready, bus.spi_rdata[31:1]};
`endif

  // ---------------------------------------------------------------------------
  // clkdiv configuration: latest cfg_load wins, applied between words
  // ---------------------------------------------------------------------------
  // CFG takes clkdiv_d so a cfg_load landing on the IDLE->CFG edge is not lost
  assign clkdiv_d = cfg_load ? cfg_clkdiv : clkdiv_q;

  // clkdiv register and pending flag
  always_ff @(posedge clk) begin
    if (rst) begin
      clkdiv_q      <= CLKDIV_RST;
      cfg_pending_q <= 1'b0;
    end else begin
      clkdiv_q <= clkdiv_d;
      if (cfg_load)                cfg_pending_q <= 1'b1;
      else if (state_q == ST_CFG)  cfg_pending_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  // Next state and the bus command for that state
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cs_d    = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = ADDR_DATA;
    wdata_d = '0;

    case (state_q)
      // The first cycle after reset has no poll on the bus yet, so qualify the status read
      ST_SYNC:   if (bus.spi_rd && (bus.spi_addr == ADDR_STAT) && !bus.spi_rdata[0])
                   state_d = ST_CFG;
      ST_CFG:    state_d = ST_IDLE;
      ST_IDLE:   if (cfg_pending_q)  state_d = ST_CFG;
                 else if (!tx_empty) state_d = ST_WRITE;
      ST_WRITE:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_POLL;
`ifdef SPI_RX_CAPTURE_EN
      ST_POLL:   if (!bus.spi_rdata[0]) state_d = ST_READ;
      ST_READ:   if (!rx_full) state_d = ST_IDLE;
`else
      ST_POLL:   if (!bus.spi_rdata[0]) state_d = ST_IDLE;
`endif
      default:   state_d = ST_SYNC;
    endcase

    case (state_d)
      ST_SYNC:  begin cs_d = 1'b1; rd_d = 1'b1; addr_d = ADDR_STAT; end
      ST_CFG:   begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_DIV;  wdata_d = {24'b0, clkdiv_d}; end
      ST_WRITE: begin cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_DATA; wdata_d = tx_mem[tx_rd_ptr[AW-1:0]]; end
      ST_POLL:  begin cs_d = 1'b1; rd_d = 1'b1; addr_d = ADDR_STAT; end
`ifdef SPI_RX_CAPTURE_EN
      ST_READ:  begin cs_d = 1'b1; rd_d = 1'b1; addr_d = ADDR_DATA; end
`endif
      default:  ;
    endcase
  end

  // State register and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SYNC;
      bus.spi_cs    <= 1'b0;
      bus.spi_rd    <= 1'b0;
      bus.spi_wr    <= 1'b0;
      bus.spi_addr  <= ADDR_DATA;
      bus.spi_wdata <= '0;
    end else begin
      state_q       <= state_d;
      bus.spi_cs    <= cs_d;
      bus.spi_rd    <= rd_d;
      bus.spi_wr    <= wr_d;
      bus.spi_addr  <= addr_d;
      bus.spi_wdata <= wdata_d;
    end
  end

  // Completed-word counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst)            xfer_count <= '0;
    else if (word_done) xfer_count <= xfer_count + 16'd1;
  end

  // IDLE is only reached after a not-busy status read, so the master is known idle here
  assign idle = !rst && (state_q == ST_IDLE) && tx_empty;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb_spi_xfer_sequencer: drives spi_xfer_sequencer against a behavioural model of the
// bus-mapped SPI master (loopback: received word equals the word sent, transfer lasts
// 64*(clkdiv+1) clk). Works for builds with or without SPI_RX_CAPTURE_EN.
module tb_spi_xfer_sequencer;
  localparam int DEPTH = 8;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic [7:0]  cfg_clkdiv = '0;
  logic        cfg_load   = 1'b0;
  logic        idle;
  logic [15:0] xfer_count;

  spi_xfer_sequencer_if bus ();

  spi_xfer_sequencer #(.DEPTH(DEPTH), .CLKDIV_RST(8'd4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_clkdiv (cfg_clkdiv),
    .cfg_load   (cfg_load),
    .idle       (idle),
    .xfer_count (xfer_count),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- SPI master model (no reset, like the real one) ----------------
  logic [7:0]  m_div   = 8'hFF;
  logic        m_busy  = 1'b0;
  int          m_cnt   = 0;
  logic [31:0] m_shift = '0;
  logic [31:0] m_rx    = '0;
  logic [31:0] wlog_data [$];
  logic [7:0]  wlog_div  [$];
  int          n_cfg = 0, n_polls = 0, n_rd_data = 0, bus_err = 0, wr_busy_err = 0;
  logic [31:0] last_cfg = '0;
  logic [31:0] rx_exp [$];

  assign bus.spi_rdata = (bus.spi_addr == 2'b00) ? m_rx :
                         (bus.spi_addr == 2'b01) ? {31'b0, m_busy} :
                         (bus.spi_addr == 2'b10) ? {24'b0, m_div} : 32'b0;

  always @(posedge clk) begin
    if (bus.spi_rd === 1'b1 && bus.spi_wr === 1'b1) bus_err++;
    if ((bus.spi_rd === 1'b1 || bus.spi_wr === 1'b1) && bus.spi_cs !== 1'b1) bus_err++;
    if (bus.spi_cs === 1'b1 && bus.spi_rd === 1'b1 && bus.spi_addr == 2'b01) n_polls++;
    if (bus.spi_cs === 1'b1 && bus.spi_rd === 1'b1 && bus.spi_addr == 2'b00) n_rd_data++;
    if (bus.spi_cs === 1'b1 && bus.spi_wr === 1'b1 && m_busy) wr_busy_err++;
    if (m_busy) begin
      if (m_cnt <= 1) begin
        m_busy <= 1'b0;
        m_rx   <= m_shift;
      end
      m_cnt <= m_cnt - 1;
    end
    if (bus.spi_cs === 1'b1 && bus.spi_wr === 1'b1) begin
      if (bus.spi_addr == 2'b10) begin
        m_div    <= bus.spi_wdata[7:0];
        last_cfg =  bus.spi_wdata;
        n_cfg++;
      end else if (bus.spi_addr == 2'b00 && !m_busy) begin
        m_busy  <= 1'b1;
        m_cnt   <= 64 * (int'(m_div) + 1);
        m_shift <= bus.spi_wdata;
        wlog_data.push_back(bus.spi_wdata);
        wlog_div.push_back(m_div);
      end
    end
  end

  function automatic logic [31:0] wdata_at(input int i);
    if (i < wlog_data.size()) return wlog_data[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [7:0] wdiv_at(input int i);
    if (i < wlog_div.size()) return wlog_div[i];
    return 8'hxx;
  endfunction

  // ---------------- stimulus helpers (no comparisons inside) ----------------
  task automatic push_word(input logic [31:0] w, output bit ok);
    ok = 1'b0;
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      if (bus.tx_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_xfer(input logic [15:0] target, input int budget, output bit ok);
    int t;
    t = 0;
    while (xfer_count !== target && t < budget) begin @(negedge clk); t++; end
    ok = (xfer_count === target);
  endtask

  task automatic wait_write(input int n_before, input int budget, output bit ok);
    int t;
    t = 0;
    while (wlog_data.size() <= n_before && t < budget) begin @(negedge clk); t++; end
    ok = (wlog_data.size() > n_before);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int t;
    rst = 1'b1; bus.tx_valid = 1'b1; bus.tx_data = 32'hDEAD_BEEF; bus.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.tx_ready !== 1'b0) $display("FAIL rst_tx_ready: got %b want 0", bus.tx_ready); else n_pass++;
    n_checks++; if (bus.rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b want 0", bus.rx_valid); else n_pass++;
    n_checks++; if (idle !== 1'b0) $display("FAIL rst_idle: got %b want 0", idle); else n_pass++;
    n_checks++; if (xfer_count !== 16'd0) $display("FAIL rst_count: got %0d want 0", xfer_count); else n_pass++;
    n_checks++;
    if ({bus.spi_cs, bus.spi_rd, bus.spi_wr, bus.spi_addr, bus.spi_wdata} !== 37'd0)
      $display("FAIL rst_bus: cs=%b rd=%b wr=%b addr=%b wdata=%h want all 0",
               bus.spi_cs, bus.spi_rd, bus.spi_wr, bus.spi_addr, bus.spi_wdata);
    else n_pass++;
    rst = 1'b0; bus.tx_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.spi_cs, bus.spi_rd, bus.spi_wr, bus.spi_addr} !== 5'b11001)
      $display("FAIL sync_poll: cs/rd/wr/addr=%b want 11001", {bus.spi_cs, bus.spi_rd, bus.spi_wr, bus.spi_addr});
    else n_pass++;
    n_checks++; if (bus.tx_ready !== 1'b1) $display("FAIL post_rst_tx_ready: got %b want 1", bus.tx_ready); else n_pass++;
    n_checks++; if (idle !== 1'b0) $display("FAIL sync_idle: got %b want 0", idle); else n_pass++;
    t = 1;
    while (idle !== 1'b1 && t < 4) begin @(negedge clk); t++; end
    n_checks++; if (idle !== 1'b1) $display("FAIL idle_within_4: idle=%b after %0d clk want 1", idle, t); else n_pass++;
    n_checks++; if (n_cfg !== 1 || last_cfg !== 32'd4) $display("FAIL rst_cfg_write: count=%0d value=%0d want 1 write of 4", n_cfg, last_cfg); else n_pass++;
    n_checks++; if (wlog_data.size() !== 0) $display("FAIL rst_no_data_write: got %0d writes want 0", wlog_data.size()); else n_pass++;
  endtask

  task automatic test_single();
    bit ok;
    int wb, rdb;
    logic [15:0] base;
    wb = wlog_data.size(); rdb = n_rd_data; base = xfer_count;
    push_word(32'hA5A5_0F0F, ok);
    n_checks++; if (!ok) $display("FAIL single_push: tx_ready never high, got 0 want 1"); else n_pass++;
    wait_xfer(base + 16'd1, 3000, ok);
    n_checks++; if (xfer_count !== base + 16'd1) $display("FAIL single_count: got %0d want %0d", xfer_count, base + 16'd1); else n_pass++;
    n_checks++; if (wdata_at(wb) !== 32'hA5A5_0F0F) $display("FAIL single_wr_data: got %h want a5a50f0f", wdata_at(wb)); else n_pass++;
    n_checks++; if (wdiv_at(wb) !== 8'd4) $display("FAIL single_div: got %0d want 4", wdiv_at(wb)); else n_pass++;
`ifdef SPI_RX_CAPTURE_EN
    n_checks++;
    if (bus.rx_valid !== 1'b1 || bus.rx_data !== 32'hA5A5_0F0F)
      $display("FAIL single_rx: valid=%b data=%h want 1 a5a50f0f", bus.rx_valid, bus.rx_data);
    else n_pass++;
    bus.rx_ready = 1'b1; @(negedge clk); bus.rx_ready = 1'b0;
    n_checks++; if (bus.rx_valid !== 1'b0) $display("FAIL single_rx_pop: valid=%b want 0", bus.rx_valid); else n_pass++;
`else
    n_checks++; if (bus.rx_valid !== 1'b0) $display("FAIL single_rx_valid: got %b want 0", bus.rx_valid); else n_pass++;
    n_checks++; if (n_rd_data !== rdb) $display("FAIL single_no_rd00: got %0d reads want %0d", n_rd_data, rdb); else n_pass++;
`endif
    repeat (3) @(negedge clk);
    n_checks++; if (idle !== 1'b1) $display("FAIL single_idle: got %b want 1", idle); else n_pass++;
  endtask

`ifdef SPI_RX_CAPTURE_EN
  task automatic drain_rx(input int n);
    int t;
    logic [31:0] want;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (bus.rx_valid !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
      want = (rx_exp.size() > 0) ? rx_exp.pop_front() : 32'hxxxx_xxxx;
      n_checks++;
      if (bus.rx_valid !== 1'b1 || bus.rx_data !== want)
        $display("FAIL rx_order[%0d]: valid=%b data=%h want 1 %h", i, bus.rx_valid, bus.rx_data, want);
      else n_pass++;
      bus.rx_ready = 1'b1; @(negedge clk); bus.rx_ready = 1'b0;
    end
  endtask
`endif

  task automatic test_back_to_back();
    bit ok, full_seen;
    int wb, accepted;
    logic [15:0] base;
    logic [31:0] words [$];
    wb = wlog_data.size(); base = xfer_count;
    accepted = 0; full_seen = 1'b0;
    bus.tx_valid = 1'b1;
    for (int c = 0; c < 40 && !full_seen; c++) begin
      bus.tx_data = $urandom;
      if (bus.tx_ready === 1'b1) begin
        words.push_back(bus.tx_data);
        rx_exp.push_back(bus.tx_data);
        accepted++;
        @(negedge clk);
      end else full_seen = 1'b1;
    end
    bus.tx_valid = 1'b0;
    n_checks++;
    if (!full_seen || (accepted - (wlog_data.size() - wb)) !== DEPTH)
      $display("FAIL b2b_full: full_seen=%b occupancy=%0d want 1 %0d", full_seen, accepted - (wlog_data.size() - wb), DEPTH);
    else n_pass++;
`ifdef SPI_RX_CAPTURE_EN
    wait_xfer(base + 16'(DEPTH), 6000, ok);
    begin
      int t, rb;
      t = 0;
      while ((wlog_data.size() < wb + accepted || m_busy) && t < 2000) begin @(negedge clk); t++; end
      repeat (20) @(negedge clk);
      n_checks++; if (xfer_count !== base + 16'(DEPTH)) $display("FAIL b2b_stall_count: got %0d want %0d", xfer_count, base + 16'(DEPTH)); else n_pass++;
      rb = n_rd_data;
      repeat (5) @(negedge clk);
      n_checks++; if (n_rd_data - rb !== 5) $display("FAIL b2b_stall_read: got %0d reads want 5", n_rd_data - rb); else n_pass++;
    end
    drain_rx(accepted);
`endif
    wait_xfer(base + 16'(accepted), 6000, ok);
    n_checks++; if (xfer_count !== base + 16'(accepted)) $display("FAIL b2b_count: got %0d want %0d", xfer_count, base + 16'(accepted)); else n_pass++;
    for (int i = 0; i < accepted; i++) begin
      n_checks++;
      if (wdata_at(wb + i) !== words[i]) $display("FAIL b2b_order[%0d]: got %h want %h", i, wdata_at(wb + i), words[i]);
      else n_pass++;
    end
  endtask

  task automatic test_cfg_mid_word();
    bit ok;
    int wb, cb;
    logic [15:0] base;
    logic [31:0] a, b, c;
    wb = wlog_data.size(); cb = n_cfg; base = xfer_count;
    a = $urandom; b = $urandom; c = $urandom;
    push_word(a, ok); rx_exp.push_back(a);
    wait_write(wb, 200, ok);
    repeat (5) @(negedge clk);
    // Two back-to-back loads: the second value must win
    cfg_clkdiv = 8'd7; cfg_load = 1'b1; @(negedge clk);
    cfg_clkdiv = 8'd2;                  @(negedge clk);
    cfg_load = 1'b0;
    push_word(b, ok); rx_exp.push_back(b);
    wait_xfer(base + 16'd2, 3000, ok);
    n_checks++; if (xfer_count !== base + 16'd2) $display("FAIL cfg_count: got %0d want %0d", xfer_count, base + 16'd2); else n_pass++;
    n_checks++; if (wdiv_at(wb) !== 8'd4) $display("FAIL cfg_cur_word_div: got %0d want 4", wdiv_at(wb)); else n_pass++;
    n_checks++; if (int'(wdiv_at(wb + 1)) + 1 !== 3) $display("FAIL cfg_half_period: got %0d want 3", int'(wdiv_at(wb + 1)) + 1); else n_pass++;
    n_checks++; if (n_cfg - cb !== 1 || last_cfg !== 32'd2) $display("FAIL cfg_write: count=%0d value=%0d want 1 write of 2", n_cfg - cb, last_cfg); else n_pass++;
    n_checks++; if (wdata_at(wb) !== a || wdata_at(wb + 1) !== b) $display("FAIL cfg_data: got %h %h want %h %h", wdata_at(wb), wdata_at(wb + 1), a, b); else n_pass++;
    cfg_clkdiv = 8'd0; cfg_load = 1'b1; @(negedge clk); cfg_load = 1'b0;
    push_word(c, ok); rx_exp.push_back(c);
    wait_xfer(base + 16'd3, 3000, ok);
    n_checks++; if (xfer_count !== base + 16'd3) $display("FAIL div0_count: got %0d want %0d", xfer_count, base + 16'd3); else n_pass++;
    n_checks++; if (wdiv_at(wb + 2) !== 8'd0 || wdata_at(wb + 2) !== c) $display("FAIL div0_word: div=%0d data=%h want 0 %h", wdiv_at(wb + 2), wdata_at(wb + 2), c); else n_pass++;
`ifdef SPI_RX_CAPTURE_EN
    drain_rx(3);
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    int wb, pb, cb, t;
    rx_exp.delete();
    cfg_clkdiv = 8'd4; cfg_load = 1'b1; @(negedge clk); cfg_load = 1'b0;
    wb = wlog_data.size();
    push_word($urandom, ok);
    wait_write(wb, 200, ok);
    repeat (10) @(negedge clk);
    pb = n_polls; cb = n_cfg;
    rst = 1'b1; repeat (2) @(negedge clk);
    n_checks++; if (bus.rx_valid !== 1'b0 || bus.tx_ready !== 1'b0) $display("FAIL mid_rst_flags: rx_valid=%b tx_ready=%b want 0 0", bus.rx_valid, bus.tx_ready); else n_pass++;
    rst = 1'b0;
    t = 0;
    while (idle !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    n_checks++; if (idle !== 1'b1) $display("FAIL mid_rst_idle: got %b want 1", idle); else n_pass++;
    n_checks++; if (n_polls - pb < 2) $display("FAIL mid_rst_sync_polls: got %0d want >=2", n_polls - pb); else n_pass++;
    n_checks++; if (n_cfg - cb !== 1 || m_div !== 8'd4) $display("FAIL mid_rst_cfg: count=%0d div=%0d want 1 4", n_cfg - cb, m_div); else n_pass++;
    n_checks++; if (xfer_count !== 16'd0 || bus.rx_valid !== 1'b0) $display("FAIL mid_rst_lost: count=%0d rx_valid=%b want 0 0", xfer_count, bus.rx_valid); else n_pass++;
    repeat (50) @(negedge clk);
    n_checks++; if (wlog_data.size() !== wb + 1) $display("FAIL mid_rst_no_resend: writes=%0d want %0d", wlog_data.size(), wb + 1); else n_pass++;
  endtask

  task automatic test_bus_rules();
    n_checks++; if (bus_err !== 0) $display("FAIL bus_rd_wr_cs: got %0d violations want 0", bus_err); else n_pass++;
    n_checks++; if (wr_busy_err !== 0) $display("FAIL wr_while_busy: got %0d want 0", wr_busy_err); else n_pass++;
`ifndef SPI_RX_CAPTURE_EN
    n_checks++; if (n_rd_data !== 0) $display("FAIL no_rx_rd00: got %0d reads want 0", n_rd_data); else n_pass++;
`endif
  endtask

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    bus.rx_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_cfg_mid_word();
    test_reset_mid();
    test_bus_rules();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
